// File: rtl/shiftreg_rr_arbiter_pkg.sv
// Shared types for the round-robin arbiter in front of the shift-register pipeline.
// Holds the arbiter state encoding and the requester-tag width helper.
package shiftreg_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shiftreg_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Scanning from the far end lets the nearest match overwrite earlier ones.
module rr_pick
    import shiftreg_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  grant,
    output logic             any_valid
);

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        any_valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req[idx]) begin
                grant     = ID_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shiftreg_rr_arbiter.sv
// Round-robin arbiter feeding a shared valid/ready pipeline stage.
// A grant stays locked to one requester until its end-of-packet beat is taken.
module shiftreg_rr_arbiter
    import shiftreg_arb_pkg::*;
#(
    parameter int  N_REQ   = 4,
    parameter int  D_WIDTH = 6,
    localparam int ID_W    = id_width(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ*D_WIDTH-1:0]   req_data,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic [D_WIDTH-1:0]         up_data,
    output logic [ID_W-1:0]            up_id,
    output logic                       up_last,
    output logic                       up_valid,
    input  logic                       up_ready
);

    arb_state_e         state;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    lock_id;
    logic [ID_W-1:0]    pick_id;
    logic [ID_W-1:0]    grant;
    logic               pick_any;
    logic               has_grant;
    logic               stage_ready;
    logic               accept;
    logic [D_WIDTH-1:0] sel_data;
    logic               sel_last;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
        return (id == ID_W'(N_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    rr_pick #(
        .N_REQ(N_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req      (req_valid),
        .ptr      (ptr),
        .grant    (pick_id),
        .any_valid(pick_any)
    );

    assign stage_ready = !up_valid || up_ready;

    // A locked grant is held even through bubbles so packets never interleave.
    always_comb begin
        grant     = pick_id;
        has_grant = pick_any;
        if (state == LOCKED) begin
            grant     = lock_id;
            has_grant = 1'b1;
        end
    end

    always_comb begin
        req_ready = '0;
        sel_data  = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                req_ready[i] = !rst && stage_ready && has_grant;
                sel_data     = req_data[i*D_WIDTH +: D_WIDTH];
                sel_last     = req_last[i];
            end
        end
    end

    assign accept = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            up_valid <= 1'b0;
            up_data  <= '0;
            up_id    <= '0;
            up_last  <= 1'b0;
            state    <= IDLE;
            ptr      <= '0;
            lock_id  <= '0;
        end else begin
            if (stage_ready) begin
                up_valid <= accept;
                if (accept) begin
                    up_data <= sel_data;
                    up_id   <= grant;
                    up_last <= sel_last;
                end
            end
            if (accept) begin
                if (sel_last) begin
                    state <= IDLE;
                    ptr   <= wrap_inc(grant);
                end else begin
                    state   <= LOCKED;
                    lock_id <= grant;
                end
            end
        end
    end

endmodule

// File: tb/tb_shiftreg_rr_arbiter.sv
// Directed and scoreboarded random bench for shiftreg_rr_arbiter.
// Four requesters, 6-bit payload; requester i's idle payload is i*8.
module tb_shiftreg_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 6;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   up_data;
    logic [IW-1:0]   up_id;
    logic            up_last;
    logic            up_valid;
    logic            up_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shiftreg_rr_arbiter #(
        .N_REQ  (N),
        .D_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_data (req_data),
        .req_valid(req_valid),
        .req_last (req_last),
        .req_ready(req_ready),
        .up_data  (up_data),
        .up_id    (up_id),
        .up_last  (up_last),
        .up_valid (up_valid),
        .up_ready (up_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_data();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(i * 8);
    endtask

    task automatic do_reset(input logic [N-1:0] v, input logic [N-1:0] l);
        rst       = 1'b1;
        up_ready  = 1'b1;
        req_valid = v;
        req_last  = l;
        set_idle_data();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        up_ready  = 1'b1;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        set_idle_data();
        tick();
        tick();
        n_checks++;
        if ({up_valid, up_id, up_last, up_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b id=%0d l=%b d=%0d want all 0",
                     up_valid, up_id, up_last, up_data);
        end
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready got %b want 0000", req_ready);
        end
    endtask

    task automatic test_round_robin();
        do_reset(4'b1111, 4'b1111);
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if ({up_valid, up_id, up_last, up_data} !==
                {1'b1, IW'(k % 4), 1'b1, DW'((k % 4) * 8)}) begin
                n_fail++;
                $display("FAIL rr_seq[%0d] got v=%b id=%0d d=%0d want id=%0d",
                         k, up_valid, up_id, up_data, k % 4);
            end
        end
    endtask

    task automatic test_lock();
        do_reset(4'b0001, 4'b1111);
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0111;
        req_last  = 4'b0011;
        req_data[2*DW +: DW] = 6'd16;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL lock_pick got %b want 0100", req_ready);
        end
        tick();
        n_checks++;
        if ({up_valid, up_id, up_last, up_data} !== {1'b1, 2'd2, 1'b0, 6'd16}) begin
            n_fail++;
            $display("FAIL lock_beat1 got id=%0d l=%b d=%0d want 2/0/16",
                     up_id, up_last, up_data);
        end
        req_data[2*DW +: DW] = 6'd17;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL lock_hold got %b want 0100", req_ready);
        end
        tick();
        n_checks++;
        if ({up_valid, up_id, up_last, up_data} !== {1'b1, 2'd2, 1'b0, 6'd17}) begin
            n_fail++;
            $display("FAIL lock_beat2 got id=%0d l=%b d=%0d want 2/0/17",
                     up_id, up_last, up_data);
        end
        req_data[2*DW +: DW] = 6'd18;
        req_last = 4'b0111;
        tick();
        n_checks++;
        if ({up_valid, up_id, up_last, up_data} !== {1'b1, 2'd2, 1'b1, 6'd18}) begin
            n_fail++;
            $display("FAIL lock_beat3 got id=%0d l=%b d=%0d want 2/1/18",
                     up_id, up_last, up_data);
        end
        req_valid = 4'b0011;
        set_idle_data();
        tick();
        n_checks++;
        if ({up_valid, up_id, up_last, up_data} !== {1'b1, 2'd0, 1'b1, 6'd0}) begin
            n_fail++;
            $display("FAIL lock_after got id=%0d d=%0d want 0/0", up_id, up_data);
        end
    endtask

    task automatic test_backpressure();
        do_reset(4'b1111, 4'b1111);
        tick();
        up_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if ({req_ready, up_valid, up_id, up_last, up_data} !==
                {4'b0000, 1'b1, 2'd0, 1'b1, 6'd0}) begin
                n_fail++;
                $display("FAIL stall[%0d] got rdy=%b v=%b id=%0d d=%0d want 0000/1/0/0",
                         c, req_ready, up_valid, up_id, up_data);
            end
        end
        up_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            n_checks++;
            if ({up_valid, up_id, up_data} !== {1'b1, IW'(k % 4), DW'((k % 4) * 8)}) begin
                n_fail++;
                $display("FAIL stall_release[%0d] got v=%b id=%0d want id=%0d",
                         k, up_valid, up_id, k % 4);
            end
        end
    endtask

    task automatic test_bubble();
        do_reset(4'b0001, 4'b1111);
        tick();
        req_valid = 4'b1010;
        req_last  = 4'b1000;
        tick();
        n_checks++;
        if ({up_valid, up_id, up_last} !== {1'b1, 2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL bubble_first got v=%b id=%0d l=%b want 1/1/0",
                     up_valid, up_id, up_last);
        end
        req_valid = 4'b1000;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if ({up_valid, req_ready} !== {1'b0, 4'b0010}) begin
                n_fail++;
                $display("FAIL bubble[%0d] got v=%b rdy=%b want 0/0010",
                         c, up_valid, req_ready);
            end
        end
        req_valid = 4'b1010;
        req_last  = 4'b1010;
        tick();
        n_checks++;
        if ({up_valid, up_id, up_last} !== {1'b1, 2'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL bubble_last got v=%b id=%0d l=%b want 1/1/1",
                     up_valid, up_id, up_last);
        end
        tick();
        n_checks++;
        if ({up_valid, up_id, up_data} !== {1'b1, 2'd3, 6'd24}) begin
            n_fail++;
            $display("FAIL bubble_next got v=%b id=%0d d=%0d want 1/3/24",
                     up_valid, up_id, up_data);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset(4'b1000, 4'b0000);
        tick();
        tick();
        n_checks++;
        if ({up_valid, up_id, up_last} !== {1'b1, 2'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL midrst_locked got v=%b id=%0d l=%b want 1/3/0",
                     up_valid, up_id, up_last);
        end
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        tick();
        n_checks++;
        if ({up_valid, up_id, up_last, up_data, req_ready} !== '0) begin
            n_fail++;
            $display("FAIL midrst_clear got v=%b id=%0d rdy=%b want 0/0/0000",
                     up_valid, up_id, req_ready);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if ({up_valid, up_id} !== {1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL midrst_first got v=%b id=%0d want 1/0", up_valid, up_id);
        end
        tick();
        n_checks++;
        if ({up_valid, up_id} !== {1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL midrst_second got v=%b id=%0d want 1/1", up_valid, up_id);
        end
    endtask

    task automatic test_random();
        int          seq_in[N];
        int          seq_out[N];
        int          bidx[N];
        int          plen[N];
        int          owner;
        int          id;
        logic [N-1:0] acc;
        bit          gen;
        owner = -1;
        acc   = '0;
        for (int i = 0; i < N; i++) begin
            seq_in[i]  = 0;
            seq_out[i] = 0;
            bidx[i]    = 0;
            plen[i]    = 1;
        end
        do_reset(4'b0000, 4'b0000);
        for (int c = 0; c < 460; c++) begin
            gen = (c < 400);
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    bidx[i]      = req_last[i] ? 0 : bidx[i] + 1;
                    seq_in[i]    = seq_in[i] + 1;
                    req_valid[i] = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && (gen || bidx[i] != 0) && ($urandom_range(1, 0) == 1)) begin
                    if (bidx[i] == 0) plen[i] = $urandom_range(3, 1);
                    req_valid[i]         = 1'b1;
                    req_data[i*DW +: DW] = {2'(i), 4'(seq_in[i])};
                    req_last[i]          = (bidx[i] == plen[i] - 1);
                end
            end
            up_ready = gen ? 1'($urandom_range(1, 0)) : 1'b1;
            #1;
            n_checks++;
            if (!$onehot0(req_ready)) begin
                n_fail++;
                $display("FAIL rand_onehot cyc %0d got rdy=%b want at most one bit",
                         c, req_ready);
            end
            acc = req_valid & req_ready;
            if (up_valid && up_ready) begin
                id = int'(up_id);
                n_checks++;
                if (up_data !== {2'(id), 4'(seq_out[id])} ||
                    (owner != -1 && owner != id)) begin
                    n_fail++;
                    $display("FAIL rand_out cyc %0d got id=%0d d=%0h owner=%0d want d=%0h owner=%0d",
                             c, id, up_data, owner, {2'(id), 4'(seq_out[id])}, id);
                end
                seq_out[id] = seq_out[id] + 1;
                owner       = up_last ? -1 : id;
            end
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (seq_out[i] != seq_in[i] || bidx[i] != 0) begin
                n_fail++;
                $display("FAIL rand_count[%0d] got out=%0d in=%0d open=%0d want equal, open 0",
                         i, seq_out[i], seq_in[i], bidx[i]);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_data  = '0;
        req_valid = '0;
        req_last  = '0;
        up_ready  = 1'b1;
        test_reset();
        test_round_robin();
        test_lock();
        test_backpressure();
        test_bubble();
        test_reset_mid_packet();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shiftreg_rr_arbiter.md
SHIFTREG_RR_ARBITER -- requirements
Module: shiftreg_rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4; number of requesters sharing the 4-deep valid/ready shift-register pipeline, legal range 2..8.
REQ-002 Parameter D_WIDTH, default 6; payload width per beat, equal to the pipeline's D_WIDTH.
REQ-003 Derived constant ID_W = max(1, clog2(N_REQ)); width of the requester tag.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_data  input  N_REQ*D_WIDTH  per-requester payload, requester i in bits [i*D_WIDTH +: D_WIDTH].
REQ-007 req_valid  input  N_REQ  per-requester beat valid.
REQ-008 req_last  input  N_REQ  per-requester end-of-packet marker for the current beat.
REQ-009 req_ready  output  N_REQ  per-requester accept; at most one bit high in any cycle.
REQ-010 up_data  output  D_WIDTH  payload toward the shared pipeline.
REQ-011 up_id  output  ID_W  requester index of the beat on up_data.
REQ-012 up_last  output  1  end-of-packet marker of the beat on up_data.
REQ-013 up_valid  output  1  beat on up_data/up_id/up_last is valid.
REQ-014 up_ready  input  1  pipeline accept (the pipeline drives it from its down_ready).

Function
REQ-015 Output stage: one register holding up_data/up_id/up_last/up_valid; stage_ready = !up_valid || up_ready.
REQ-016 A requester beat is accepted when req_valid[i] && req_ready[i]; accepted beat appears on up_* the next cycle (latency 1).
REQ-017 req_ready[i] is high only when stage_ready=1 and i is the current grant; req_ready does not depend on req_valid of other requesters beyond grant selection.
REQ-018 Load and drain in the same cycle are allowed: full throughput of one beat per cycle while up_ready=1.
REQ-019 When stage_ready=0, up_* hold value and no req_ready is asserted.
REQ-020 State machine IDLE/LOCKED; IDLE: grant = first i with req_valid[i]=1 searching ptr, ptr+1, ... mod N_REQ.
REQ-021 IDLE, beat accepted with req_last=1: stay IDLE, ptr <= grant+1 mod N_REQ.
REQ-022 IDLE, beat accepted with req_last=0: go LOCKED, lock_id <= grant.
REQ-023 LOCKED: grant = lock_id only, regardless of other req_valid; return to IDLE and ptr <= lock_id+1 mod N_REQ when a beat with req_last=1 is accepted.
REQ-024 LOCKED with req_valid[lock_id]=0 (bubble): no beat accepted, state held, other requesters stay blocked.
REQ-025 No valid requesters in IDLE: no grant, ptr unchanged, up_valid clears once drained.
REQ-026 Pointer wraps from N_REQ-1 to 0.

Reset
REQ-027 While rst=1: up_valid=0, up_data=0, up_id=0, up_last=0, req_ready=0, state=IDLE, ptr=0, lock_id=0.
REQ-028 Reset mid-packet discards the partial packet and the held beat; first cycle after rst deasserts arbitrates from ptr=0.

Structure
REQ-029 Shared package shiftreg_arb_pkg holds the state enum (IDLE, LOCKED) and the ID_W derivation function.
REQ-030 Sub-module rr_pick: combinational N_REQ-wide round-robin priority picker (inputs req mask, ptr; outputs grant index, any_valid).

Verification
REQ-031 N_REQ=4, req_valid=4'b1111 all last=1, up_ready=1 -> up_id sequence 0,1,2,3,0 on consecutive cycles, first beat one cycle after reset release.
REQ-032 Requester 2 sends 3-beat packet (last on beat 3) while 0 and 1 valid -> up_id 2,2,2 contiguous, then 3 is skipped if idle, next grant 0.
REQ-033 up_ready=0 for 5 cycles with all requesters valid -> up_* stable, req_ready=0 throughout, no beat lost or duplicated after release.
REQ-034 Requester 1 locked, deasserts req_valid for 2 cycles mid-packet while 3 valid -> no beat from 3 until 1's last beat accepted.
REQ-035 rst asserted during LOCKED packet from requester 3 -> next cycle up_valid=0, state IDLE, ptr=0; fresh all-valid traffic yields up_id 0 first.
REQ-036 Random traffic, up_ready random 50% -> scoreboard per-requester order preserved, packets never interleaved, at most one req_ready bit high.
